// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: computes the actual control-flow outcome, redirects fetch
// on a mispredict and returns a registered predictor-training bundle.
// Optional macro BRU_PERF_CNT_EN adds saturating control-flow / mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned PHT_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_valid,
    input  logic                     ex_advance,
    input  logic [6:0]               ex_opcode,
    input  logic [2:0]               ex_funct3,
    input  logic [31:0]              ex_pc,
    input  logic [31:0]              ex_rs1_data,
    input  logic [31:0]              ex_rs2_data,
    input  logic [31:0]              ex_imm,
    input  logic [31:0]              ex_predicted_pc,
    input  logic [PHT_IDX_WIDTH-1:0] ex_pht_idx,
    input  logic                     redirect_ready,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     flush,
    output logic [31:0]              link_data,
    output logic                     upd_valid,
    output logic                     upd_is_branch,
    output logic [31:0]              upd_pc,
    output logic [PHT_IDX_WIDTH-1:0] upd_pht_idx,
    output logic                     upd_taken,
    output logic [31:0]              upd_target,
    output logic                     upd_mispredict
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]              perf_cf_count,
    output logic [31:0]              perf_mispredict_count
`endif
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e                   state_q;
    logic [31:0]              pending_q;
    logic                     upd_valid_q;
    logic                     upd_is_branch_q;
    logic [31:0]              upd_pc_q;
    logic [PHT_IDX_WIDTH-1:0] upd_pht_idx_q;
    logic                     upd_taken_q;
    logic [31:0]              upd_target_q;
    logic                     upd_mispredict_q;

    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_cf;
    logic        fire;
    logic        br_taken;
    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] actual_next;
    logic        mispredict;

    assign is_branch = (ex_opcode == OPC_BRANCH);
    assign is_jal    = (ex_opcode == OPC_JAL);
    assign is_jalr   = (ex_opcode == OPC_JALR);
    assign is_cf     = is_branch || is_jal || is_jalr;
    assign fire      = ex_valid && ex_advance && (state_q == S_IDLE);

    // Branch condition decode; funct3 010/011 are not valid branches and never take.
    always_comb begin
        br_taken = 1'b0;
        case (ex_funct3)
            3'b000:  br_taken = (ex_rs1_data == ex_rs2_data);
            3'b001:  br_taken = (ex_rs1_data != ex_rs2_data);
            3'b100:  br_taken = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
            3'b101:  br_taken = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
            3'b110:  br_taken = (ex_rs1_data <  ex_rs2_data);
            3'b111:  br_taken = (ex_rs1_data >= ex_rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    assign taken       = is_jal || is_jalr || (is_branch && br_taken);
    assign pc_plus4    = ex_pc + 32'd4;
    assign target      = is_jalr ? ((ex_rs1_data + ex_imm) & 32'hFFFF_FFFE)
                                 : (ex_pc + ex_imm);
    assign actual_next = taken ? target : pc_plus4;
    // Non-cf instructions can mispredict too when the BTB aliases them.
    assign mispredict  = (actual_next != ex_predicted_pc);

    assign link_data      = pc_plus4;
    assign redirect_valid = !reset && ((state_q == S_WAIT) || (fire && mispredict));
    assign flush          = redirect_valid;

    always_comb begin
        redirect_pc = 32'd0;
        if (!reset) begin
            if (state_q == S_WAIT) begin
                redirect_pc = pending_q;
            end else if (fire && mispredict) begin
                redirect_pc = actual_next;
            end
        end
    end

    // Redirect handshake FSM and predictor update bundle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            pending_q        <= 32'd0;
            upd_valid_q      <= 1'b0;
            upd_is_branch_q  <= 1'b0;
            upd_pc_q         <= 32'd0;
            upd_pht_idx_q    <= '0;
            upd_taken_q      <= 1'b0;
            upd_target_q     <= 32'd0;
            upd_mispredict_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fire && mispredict && !redirect_ready) begin
                        state_q   <= S_WAIT;
                        pending_q <= actual_next;
                    end
                end
                S_WAIT: begin
                    if (redirect_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            upd_valid_q <= fire && is_cf;
            if (fire && is_cf) begin
                upd_is_branch_q  <= is_branch;
                upd_pc_q         <= ex_pc;
                upd_pht_idx_q    <= ex_pht_idx;
                upd_taken_q      <= taken;
                upd_target_q     <= target;
                upd_mispredict_q <= mispredict;
            end
        end
    end

    assign upd_valid      = upd_valid_q;
    assign upd_is_branch  = upd_is_branch_q;
    assign upd_pc         = upd_pc_q;
    assign upd_pht_idx    = upd_pht_idx_q;
    assign upd_taken      = upd_taken_q;
    assign upd_target     = upd_target_q;
    assign upd_mispredict = upd_mispredict_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] cf_cnt_q;
    logic [31:0] cf_cnt_d;
    logic [31:0] mp_cnt_q;
    logic [31:0] mp_cnt_d;

    // Saturating event counters.
    always_comb begin
        cf_cnt_d = cf_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (fire && is_cf && (cf_cnt_q != 32'hFFFF_FFFF)) begin
            cf_cnt_d = cf_cnt_q + 32'd1;
        end
        if (fire && mispredict && (mp_cnt_q != 32'hFFFF_FFFF)) begin
            mp_cnt_d = mp_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cf_cnt_q <= 32'd0;
            mp_cnt_q <= 32'd0;
        end else begin
            cf_cnt_q <= cf_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign perf_cf_count         = cf_cnt_q;
    assign perf_mispredict_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes expected update bundles,
// a negedge monitor pops and compares them; redirect outputs are checked per cycle.
module tb_branch_resolve_unit;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_ADDI   = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_advance = 1'b0;
    logic [6:0]  ex_opcode = 7'd0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_pc = 32'd0;
    logic [31:0] ex_rs1_data = 32'd0;
    logic [31:0] ex_rs2_data = 32'd0;
    logic [31:0] ex_imm = 32'd0;
    logic [31:0] ex_predicted_pc = 32'd0;
    logic [4:0]  ex_pht_idx = 5'd0;
    logic        redirect_ready = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] link_data;
    logic        upd_valid;
    logic        upd_is_branch;
    logic [31:0] upd_pc;
    logic [4:0]  upd_pht_idx;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_cf_count;
    logic [31:0] perf_mispredict_count;
`endif

    branch_resolve_unit #(.PHT_IDX_WIDTH(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_valid        (ex_valid),
        .ex_advance      (ex_advance),
        .ex_opcode       (ex_opcode),
        .ex_funct3       (ex_funct3),
        .ex_pc           (ex_pc),
        .ex_rs1_data     (ex_rs1_data),
        .ex_rs2_data     (ex_rs2_data),
        .ex_imm          (ex_imm),
        .ex_predicted_pc (ex_predicted_pc),
        .ex_pht_idx      (ex_pht_idx),
        .redirect_ready  (redirect_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .link_data       (link_data),
        .upd_valid       (upd_valid),
        .upd_is_branch   (upd_is_branch),
        .upd_pc          (upd_pc),
        .upd_pht_idx     (upd_pht_idx),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_mispredict  (upd_mispredict)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_cf_count         (perf_cf_count),
        .perf_mispredict_count (perf_mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] pc;
        logic [4:0]  pht;
        logic        taken;
        logic [31:0] target;
        logic        misp;
        logic        br;
    } upd_t;

    upd_t        sb[$];
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          passes = 0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_ex(input logic v, input logic adv, input logic [6:0] opc,
                          input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm,
                          input logic [31:0] pred, input logic [4:0] pht);
        ex_valid = v; ex_advance = adv; ex_opcode = opc; ex_funct3 = f3; ex_pc = pc;
        ex_rs1_data = rs1; ex_rs2_data = rs2; ex_imm = imm; ex_predicted_pc = pred;
        ex_pht_idx = pht;
    endtask

    task automatic set_idle();
        set_ex(1'b0, 1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    // Expected update for the instruction currently driven, due one cycle after it fires.
    task automatic push_upd(input logic taken, input logic [31:0] target, input logic misp,
                            input logic br);
        upd_t e;
        e.cyc = cyc + 32'd1; e.pc = ex_pc; e.pht = ex_pht_idx; e.taken = taken;
        e.target = target; e.misp = misp; e.br = br;
        sb.push_back(e);
    endtask

    task automatic tick(input string name, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        chk({name, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({name, ".flush"}, 32'(flush), 32'(rv));
        if (rv) chk({name, ".redirect_pc"}, redirect_pc, rpc);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every upd_valid pulse must match the oldest expected bundle, in its cycle.
    always @(negedge clk) begin
        if (upd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL upd_unexpected: got upd_valid=1 pc=0x%08h expected none", upd_pc);
            end else begin
                upd_t e;
                e = sb.pop_front();
                chk("upd.cycle", cyc, e.cyc);
                chk("upd.pc", upd_pc, e.pc);
                chk("upd.pht_idx", 32'(upd_pht_idx), 32'(e.pht));
                chk("upd.taken", 32'(upd_taken), 32'(e.taken));
                chk("upd.target", upd_target, e.target);
                chk("upd.mispredict", 32'(upd_mispredict), 32'(e.misp));
                chk("upd.is_branch", 32'(upd_is_branch), 32'(e.br));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        redirect_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tick("in_reset", 1'b0, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.upd_valid", 32'(upd_valid), 32'd0);
        chk("rst.upd_target", upd_target, 32'd0);
        chk("rst.upd_pc", upd_pc, 32'd0);
        @(posedge clk); #1;

        // BEQ taken, correctly predicted
        set_ex(1, 1, OPC_BRANCH, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 32'h120, 5'd3);
        push_upd(1'b1, 32'h120, 1'b0, 1'b1);
        tick("beq", 1'b0, 32'd0);

        // BLT signed: -1 < 1 taken, predicted fall-through
        set_ex(1, 1, OPC_BRANCH, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h204, 5'd4);
        push_upd(1'b1, 32'h240, 1'b1, 1'b1);
        tick("blt", 1'b1, 32'h240);

        // BLTU same operands: not taken, target still reported
        set_ex(1, 1, OPC_BRANCH, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h204, 5'd5);
        push_upd(1'b0, 32'h240, 1'b0, 1'b1);
        tick("bltu", 1'b0, 32'd0);

        // funct3 010 never takes; predicted target so it mispredicts to pc+4
        set_ex(1, 1, OPC_BRANCH, 3'b010, 32'h800, 32'd9, 32'd9, 32'h10, 32'h810, 5'd6);
        push_upd(1'b0, 32'h810, 1'b1, 1'b1);
        tick("f3_010", 1'b1, 32'h804);

        // JAL wrapping past 2^32; link_data also wraps
        set_ex(1, 1, OPC_JAL, 3'b000, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 32'h4, 5'd7);
        push_upd(1'b1, 32'h4, 1'b0, 1'b0);
        #1 chk("jal_wrap.link_data", link_data, 32'h0);
        tick("jal_wrap", 1'b0, 32'd0);

        // JALR mispredict with fetch back-pressure for 3 cycles
        redirect_ready = 1'b0;
        set_ex(1, 1, OPC_JALR, 3'b000, 32'h1000, 32'h1003, 32'd0, 32'h4, 32'h1004, 5'd9);
        push_upd(1'b1, 32'h1006, 1'b1, 1'b0);
        #1 chk("jalr.link_data", link_data, 32'h1004);
        tick("jalr_fire", 1'b1, 32'h1006);
        set_ex(1, 1, OPC_BRANCH, 3'b000, 32'h2000, 32'd1, 32'd1, 32'h40, 32'h2004, 5'd1);
        tick("wait1", 1'b1, 32'h1006);
        tick("wait2", 1'b1, 32'h1006);
        redirect_ready = 1'b1;
        tick("wait_ack", 1'b1, 32'h1006);
        set_idle();
        tick("after_wait", 1'b0, 32'd0);

        // ADDI aliased by the BTB: redirect to pc+4, no update
        set_ex(1, 1, OPC_ADDI, 3'b000, 32'h300, 32'd0, 32'd0, 32'd1, 32'h400, 5'd2);
        tick("addi_alias", 1'b1, 32'h304);

        // BNE stalled two cycles, then resolved once on advance
        set_ex(1, 0, OPC_BRANCH, 3'b001, 32'h500, 32'd1, 32'd2, 32'h10, 32'h504, 5'd11);
        tick("bne_stall1", 1'b0, 32'd0);
        tick("bne_stall2", 1'b0, 32'd0);
        ex_advance = 1'b1;
        push_upd(1'b1, 32'h510, 1'b1, 1'b1);
        tick("bne_adv", 1'b1, 32'h510);
        set_idle();
        tick("bne_idle", 1'b0, 32'd0);

        // Reset during WAIT drops the pending redirect
        redirect_ready = 1'b0;
        set_ex(1, 1, OPC_JAL, 3'b000, 32'h600, 32'd0, 32'd0, 32'h100, 32'h604, 5'd12);
        push_upd(1'b1, 32'h700, 1'b1, 1'b0);
        tick("jal_wait", 1'b1, 32'h700);
        set_idle();
        reset = 1'b1;
        tick("rst_in_wait", 1'b0, 32'd0);
        reset = 1'b0;
        tick("after_rst", 1'b0, 32'd0);
`ifdef BRU_PERF_CNT_EN
        chk("perf_cf_rst", perf_cf_count, 32'd0);
        chk("perf_mp_rst", perf_mispredict_count, 32'd0);
`endif

        // Counter mix: 3 branches (1 mispredicted) plus an aliased ADDI
        redirect_ready = 1'b1;
        set_ex(1, 1, OPC_BRANCH, 3'b000, 32'h900, 32'd7, 32'd7, 32'h8, 32'h908, 5'd13);
        push_upd(1'b1, 32'h908, 1'b0, 1'b1);
        tick("mix_beq", 1'b0, 32'd0);
        set_ex(1, 1, OPC_BRANCH, 3'b001, 32'h904, 32'd1, 32'd1, 32'h8, 32'h908, 5'd14);
        push_upd(1'b0, 32'h90C, 1'b0, 1'b1);
        tick("mix_bne", 1'b0, 32'd0);
        set_ex(1, 1, OPC_BRANCH, 3'b101, 32'h908, 32'd5, 32'd3, 32'h20, 32'h90C, 5'd15);
        push_upd(1'b1, 32'h928, 1'b1, 1'b1);
        tick("mix_bge", 1'b1, 32'h928);
        set_ex(1, 1, OPC_ADDI, 3'b000, 32'h90C, 32'd0, 32'd0, 32'd0, 32'h800, 5'd0);
        tick("mix_addi", 1'b1, 32'h910);
        set_idle();
        tick("mix_idle", 1'b0, 32'd0);
`ifdef BRU_PERF_CNT_EN
        chk("perf_cf_count", perf_cf_count, 32'd3);
        chk("perf_mispredict_count", perf_mispredict_count, 32'd2);
`endif

        tick("drain", 1'b0, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
